// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: round-robin byte arbitration in front of a
// start/data/stop frame sequencer paced by an external baud strobe.
module uart_tx_scheduler #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_clk,
   input  logic                 req0_valid,
   input  logic [DATA_BITS-1:0] req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [DATA_BITS-1:0] req1_data,
   output logic                 req1_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 grant_id,
   output logic                 frame_done
);

   localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAlign,
      StStart,
      StData,
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic                 tx_q, tx_d;
   logic                 grant_id_q, grant_id_d;
   logic                 frame_done_q, frame_done_d;
   logic                 last_grant_q, last_grant_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;

   logic is_idle;
   logic winner;
   logic accept;

   // With both requesters pending, the one not served last goes next.
   always_comb begin
      is_idle    = (state_q == StIdle);
      winner     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
      req0_ready = is_idle & ~winner & req0_valid & ~reset;
      req1_ready = is_idle & winner & req1_valid & ~reset;
      accept     = req0_ready | req1_ready;
   end

   always_comb begin
      state_d      = state_q;
      tx_d         = tx_q;
      grant_id_d   = grant_id_q;
      frame_done_d = 1'b0;
      last_grant_d = last_grant_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (accept) begin
               shift_d      = winner ? req1_data : req0_data;
               grant_id_d   = winner;
               last_grant_d = winner;
               state_d      = StAlign;
            end
         end
         // Waiting here for the next strobe keeps every bit a full baud period.
         StAlign: begin
            if (baud_clk) begin
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_clk) begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
               state_d   = StData;
            end
         end
         StData: begin
            if (baud_clk) begin
               if (bit_cnt_q == LastBit) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (baud_clk) begin
               frame_done_d = 1'b1;
               state_d      = StIdle;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         tx_q         <= 1'b1;
         grant_id_q   <= 1'b0;
         frame_done_q <= 1'b0;
         last_grant_q <= 1'b1;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
      end else begin
         state_q      <= state_d;
         tx_q         <= tx_d;
         grant_id_q   <= grant_id_d;
         frame_done_q <= frame_done_d;
         last_grant_q <= last_grant_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = ~is_idle;
   assign grant_id   = grant_id_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized arbitration
// rounds checked against a frame-level reference model.
module tb_uart_tx_scheduler;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       baud_clk = 1'b0;
   int         baud_cnt = 0;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req1_ready;
   logic       tx;
   logic       busy;
   logic       grant_id;
   logic       frame_done;

   int tests_run = 0;
   int tests_failed = 0;
   int model_last = 1;

   uart_tx_scheduler #(.DATA_BITS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .baud_clk   (baud_clk),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .tx         (tx),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   initial forever #5 clk = ~clk;

   // Stand-in for baud_generator: one-cycle strobe every CPB clocks.
   always @(negedge clk) begin
      baud_cnt <= (baud_cnt == CPB - 1) ? 0 : baud_cnt + 1;
      baud_clk <= (baud_cnt == CPB - 2);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, want $finish before time limit");
      $fatal(1, "time limit reached");
   end

   // Presents requests (called between edges) and waits for a grant; returns the winner.
   task automatic do_req(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [7:0] d1, input bit drop_all,
                         output int who, output bit both_hi);
      req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
      #1;
      who = -1;
      both_hi = 1'b0;
      for (int i = 0; i < 64 && who < 0; i++) begin
         if (req0_ready === 1'b1 && req1_ready === 1'b1) both_hi = 1'b1;
         if (req0_ready === 1'b1) who = 0;
         else if (req1_ready === 1'b1) who = 1;
         else begin
            @(negedge clk);
            #2;
         end
      end
      if (who >= 0) begin
         @(posedge clk);
         #1;
         if (who == 0) req0_valid = 1'b0;
         else req1_valid = 1'b0;
         if (drop_all) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
   endtask

   // Records one frame cycle by cycle from the start-bit edge; returns at the
   // negedge after the stop bit's final strobe.
   task automatic capture_frame(output int wait_n, output logic [9:0] bits,
                                output int glitches, output int side_errs,
                                output logic gid, output logic fd_end,
                                output logic busy_end, output logic to);
      logic samp [80];
      wait_n = 0; bits = '0; glitches = 0; side_errs = 0;
      gid = 1'b0; fd_end = 1'b0; busy_end = 1'b1; to = 1'b0;
      do begin
         @(negedge clk);
         wait_n++;
         if (frame_done !== 1'b0) side_errs++;
      end while (tx !== 1'b0 && wait_n < 40);
      if (tx !== 1'b0) to = 1'b1;
      else begin
         gid = grant_id;
         samp[0] = tx;
         for (int i = 1; i < 80; i++) begin
            @(negedge clk);
            samp[i] = tx;
            if (frame_done !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0 ||
                req1_ready !== 1'b0) side_errs++;
         end
         for (int b = 0; b < 10; b++) bits[b] = samp[8 * b + 4];
         for (int i = 0; i < 80; i++) if (samp[i] !== samp[(i / 8) * 8 + 4]) glitches++;
         @(negedge clk);
         fd_end = frame_done;
         busy_end = busy;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 8'($urandom); req1_data = 8'($urandom);
      repeat (2) @(negedge clk);
      #1;
      tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL rst_tx: got %b want 1", tx); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
      tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL rst_gid: got %b want 0", grant_id); end
      tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL rst_fd: got %b want 0", frame_done); end
      tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;
      #1;
      tests_run++; if ({tx, busy} !== 2'b10) begin tests_failed++; $display("FAIL rst_release: got tx,busy=%b want 10", {tx, busy}); end
      model_last = 1;
   endtask

   task automatic test_single();
      int who, wn, gl, se;
      bit bh;
      logic [9:0] bits;
      logic gid, fde, be, to;
      @(negedge clk);
      #1;
      do_req(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, who, bh);
      tests_run++; if (who !== 0) begin tests_failed++; $display("FAIL t1_who: got %0d want 0", who); end
      capture_frame(wn, bits, gl, se, gid, fde, be, to);
      tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL t1_start: got no start bit, want one"); end
      tests_run++; if (bits !== 10'b1_10100101_0) begin tests_failed++; $display("FAIL t1_bits: got %b want %b", bits, 10'b1_10100101_0); end
      tests_run++; if (gl !== 0) begin tests_failed++; $display("FAIL t1_bit_len: got %0d off-cycles want 0", gl); end
      tests_run++; if (se !== 0) begin tests_failed++; $display("FAIL t1_side: got %0d bad cycles want 0", se); end
      tests_run++; if (gid !== 1'b0) begin tests_failed++; $display("FAIL t1_gid: got %b want 0", gid); end
      tests_run++; if ({fde, be} !== 2'b10) begin tests_failed++; $display("FAIL t1_done: got fd,busy=%b want 10", {fde, be}); end
      @(negedge clk);
      tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL t1_fd_pulse: got %b want 0", frame_done); end
      model_last = 0;
   endtask

   task automatic test_arbitration();
      int who, wn, gl, se;
      bit bh;
      logic [9:0] bits;
      logic gid, fde, be, to;
      logic [7:0] d [4];
      logic v0s [4];
      int exp_who [4];
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      v0s = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp_who = '{0, 1, 0, 1};
      apply_reset();
      model_last = 1;
      for (int k = 0; k < 4; k++) begin
         do_req(v0s[k], d[k], 1'b1, (k < 2) ? d[1] : d[3], v0s[k] == 1'b0, who, bh);
         tests_run++; if (who !== exp_who[k] || bh) begin tests_failed++; $display("FAIL t2_who%0d: got %0d both=%0d want %0d", k, who, bh, exp_who[k]); end
         capture_frame(wn, bits, gl, se, gid, fde, be, to);
         tests_run++; if (bits !== {1'b1, d[k], 1'b0} || to) begin tests_failed++; $display("FAIL t2_bits%0d: got %b want %b", k, bits, {1'b1, d[k], 1'b0}); end
         tests_run++; if (gid !== 1'(exp_who[k])) begin tests_failed++; $display("FAIL t2_gid%0d: got %b want %0d", k, gid, exp_who[k]); end
         tests_run++; if (se !== 0 || gl !== 0 || fde !== 1'b1) begin tests_failed++; $display("FAIL t2_frame%0d: got side=%0d gl=%0d fd=%b want 0 0 1", k, se, gl, fde); end
         model_last = exp_who[k];
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int who, wn, gl, se;
      bit bh;
      logic [9:0] bits;
      logic gid, fde, be, to;
      logic [7:0] d [3];
      for (int k = 0; k < 3; k++) d[k] = 8'($urandom);
      do_req(1'b0, 8'h00, 1'b1, d[0], 1'b0, who, bh);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) do_req(1'b0, 8'h00, 1'b1, d[k], 1'b0, who, bh);
         tests_run++; if (who !== 1) begin tests_failed++; $display("FAIL t3_who%0d: got %0d want 1", k, who); end
         if (k < 2) begin
            req1_valid = 1'b1;
            req1_data = d[k + 1];
         end
         capture_frame(wn, bits, gl, se, gid, fde, be, to);
         tests_run++; if (bits !== {1'b1, d[k], 1'b0} || to) begin tests_failed++; $display("FAIL t3_bits%0d: got %b want %b", k, bits, {1'b1, d[k], 1'b0}); end
         tests_run++; if (se !== 0 || gl !== 0 || gid !== 1'b1 || fde !== 1'b1) begin tests_failed++; $display("FAIL t3_frame%0d: got side=%0d gl=%0d gid=%b fd=%b want 0 0 1 1", k, se, gl, gid, fde); end
         if (k > 0) begin
            tests_run++; if (wn !== CPB) begin tests_failed++; $display("FAIL t3_gap%0d: got %0d clocks want %0d", k, wn, CPB); end
         end
         #1;
      end
      req1_valid = 1'b0;
      model_last = 1;
   endtask

   task automatic test_baud_collision();
      int who, wn, gl, se, n;
      bit bh;
      logic [9:0] bits;
      logic gid, fde, be, to;
      logic [7:0] d;
      d = 8'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (baud_clk !== 1'b1 && n < 20);
      do_req(1'b1, d, 1'b0, 8'h00, 1'b1, who, bh);
      tests_run++; if (who !== 0) begin tests_failed++; $display("FAIL t4_who: got %0d want 0", who); end
      capture_frame(wn, bits, gl, se, gid, fde, be, to);
      tests_run++; if (wn - 1 !== CPB) begin tests_failed++; $display("FAIL t4_latency: got %0d clocks want %0d", wn - 1, CPB); end
      tests_run++; if (bits !== {1'b1, d, 1'b0} || gl !== 0) begin tests_failed++; $display("FAIL t4_bits: got %b gl=%0d want %b", bits, gl, {1'b1, d, 1'b0}); end
      model_last = 0;
      #1;
   endtask

   task automatic test_reset_mid_frame();
      int who, wn, gl, se, n, errs;
      bit bh;
      logic [9:0] bits;
      logic gid, fde, be, to;
      logic [7:0] d, d2, d3;
      d = 8'($urandom) & 8'hF7;
      d2 = 8'($urandom); d3 = 8'($urandom);
      do_req(1'b1, d, 1'b0, 8'h00, 1'b1, who, bh);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx !== 1'b0 && n < 40);
      tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL t5_start: got tx=%b want 0", tx); end
      repeat (35) @(negedge clk);
      tests_run++; if (tx !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL t5_bit3: got tx,busy=%b want 01", {tx, busy}); end
      #1;
      reset = 1'b1;
      #1;
      tests_run++; if ({tx, busy, frame_done} !== 3'b100) begin tests_failed++; $display("FAIL t5_abort: got tx,busy,fd=%b want 100", {tx, busy, frame_done}); end
      errs = 0;
      repeat (6) begin
         @(negedge clk);
         if (frame_done !== 1'b0 || tx !== 1'b1) errs++;
      end
      #1;
      reset = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (frame_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL t5_no_done: got %0d bad cycles want 0", errs); end
      #1;
      do_req(1'b1, d2, 1'b1, d3, 1'b1, who, bh);
      tests_run++; if (who !== 0) begin tests_failed++; $display("FAIL t5_prio: got %0d want 0", who); end
      capture_frame(wn, bits, gl, se, gid, fde, be, to);
      tests_run++; if (bits !== {1'b1, d2, 1'b0} || gid !== 1'b0) begin tests_failed++; $display("FAIL t5_frame: got %b gid=%b want %b gid=0", bits, gid, {1'b1, d2, 1'b0}); end
      model_last = 0;
      #1;
   endtask

   task automatic test_idle();
      int errs;
      errs = 0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
             frame_done !== 1'b0) errs++;
      end
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL t6_idle: got %0d bad cycles want 0", errs); end
      #1;
   endtask

   // Reference: the winner is the only requester, or the one not granted last;
   // the line carries start 0, data LSB first, stop 1, each one baud period.
   task automatic test_random();
      int who, wn, gl, se, exp_who, dly;
      bit bh;
      logic [9:0] bits, exp_bits;
      logic gid, fde, be, to;
      logic [1:0] pat;
      logic [7:0] d0, d1;
      for (int r = 0; r < 10; r++) begin
         dly = $urandom_range(0, 7);
         for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            #1;
         end
         pat = 2'($urandom_range(1, 3));
         d0 = 8'($urandom); d1 = 8'($urandom);
         if (pat == 2'b11) exp_who = (model_last == 0) ? 1 : 0;
         else exp_who = (pat == 2'b01) ? 0 : 1;
         exp_bits = {1'b1, (exp_who == 0) ? d0 : d1, 1'b0};
         do_req(pat[0], d0, pat[1], d1, 1'b1, who, bh);
         tests_run++; if (who !== exp_who || bh) begin tests_failed++; $display("FAIL rnd%0d_who: got %0d both=%0d want %0d", r, who, bh, exp_who); end
         capture_frame(wn, bits, gl, se, gid, fde, be, to);
         tests_run++; if (bits !== exp_bits || to) begin tests_failed++; $display("FAIL rnd%0d_bits: got %b want %b", r, bits, exp_bits); end
         tests_run++; if (gid !== 1'(exp_who)) begin tests_failed++; $display("FAIL rnd%0d_gid: got %b want %0d", r, gid, exp_who); end
         tests_run++; if (gl !== 0 || se !== 0) begin tests_failed++; $display("FAIL rnd%0d_timing: got gl=%0d side=%0d want 0 0", r, gl, se); end
         tests_run++; if (wn - 1 < 1 || wn - 1 > CPB) begin tests_failed++; $display("FAIL rnd%0d_latency: got %0d want 1..%0d", r, wn - 1, CPB); end
         tests_run++; if ({fde, be} !== 2'b10) begin tests_failed++; $display("FAIL rnd%0d_done: got fd,busy=%b want 10", r, {fde, be}); end
         model_last = exp_who;
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_arbitration();
      test_back_to_back();
      test_baud_collision();
      test_reset_mid_frame();
      test_idle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
